isp8_ext_arb: RTL and testbench



---
 rtl/isp8_arb_pkg.sv | 14 +
 rtl/isp8_arb_rr2.sv | 21 ++
 rtl/isp8_ext_arb.sv | 185 ++++++++++++++++++
 tb/tb_isp8_ext_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isp8_arb_pkg.sv
// Shared definitions for the two-master Mico8 external bus arbiter.
// Contents: FSM state encoding and the read data returned on a forced
// (timed-out) completion.
package isp8_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage

// File: rtl/isp8_arb_rr2.sv
// Two-way round-robin picker.
// Ports:
//   req0, req1  - request from master 0 / master 1
//   last        - index of the master that won the previous arbitration
//   grant_c     - index of the selected master (valid when valid_c=1)
//   valid_c     - at least one master is requesting
module isp8_arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_c,
    output logic valid_c
);

    // On a tie the master that did not win last time is chosen.
    always_comb begin
        valid_c = req0 | req1;
        grant_c = (req0 & req1) ? ~last : req1;
    end

endmodule

// File: rtl/isp8_ext_arb.sv
// Two-master arbiter for the Mico8 external memory bus. One transaction is
// in flight at a time; ties are resolved round-robin.
// Optional feature: define ISP8_ARB_TIMEOUT_EN to force completion with
// ERR_RDATA and an m_err pulse after TIMEOUT wait cycles without s_ready.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   m0_*, m1_*          - master request side (addr/dout/rd/wr in, din/ready out)
//   s_*                 - slave side (addr/dout/rd/wr registered out, din/ready in)
//   grant, busy         - owning master index and transaction-in-progress flag
//   m_err               - timeout completion pulse (0 unless feature enabled)
// mN_ready, mN_din and m_err are combinational from s_ready/s_din.
module isp8_ext_arb
    import isp8_arb_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_addr,
    input  logic [7:0]    m0_dout,
    input  logic          m0_rd,
    input  logic          m0_wr,
    output logic [7:0]    m0_din,
    output logic          m0_ready,
    input  logic [AW-1:0] m1_addr,
    input  logic [7:0]    m1_dout,
    input  logic          m1_rd,
    input  logic          m1_wr,
    output logic [7:0]    m1_din,
    output logic          m1_ready,
    output logic [AW-1:0] s_addr,
    output logic [7:0]    s_dout,
    output logic          s_rd,
    output logic          s_wr,
    input  logic [7:0]    s_din,
    input  logic          s_ready,
    output logic          grant,
    output logic          busy,
    output logic          m_err
);

    state_t        state_q, state_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [7:0]    s_dout_q, s_dout_d;
    logic          s_rd_q, s_rd_d;
    logic          s_wr_q, s_wr_d;
    logic          busy_q, busy_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;

    logic          pick_c, pick_valid_c;
    logic          done_c, err_c, ack_c;
    logic [7:0]    rdata_c;

    isp8_arb_rr2 u_rr2 (
        .req0    (m0_rd | m0_wr),
        .req1    (m1_rd | m1_wr),
        .last    (last_q),
        .grant_c (pick_c),
        .valid_c (pick_valid_c)
    );

`ifdef ISP8_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 32'd1);

    logic [15:0] wcnt_q, wcnt_d;

    // Wait counter: zero outside WAIT, counts WAIT cycles lacking s_ready.
    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q != ST_WAIT) begin
            wcnt_d = '0;
        end else if (!s_ready) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    // A real s_ready in the limit cycle takes priority over the timeout.
    assign err_c = (state_q == ST_WAIT) && !s_ready && (wcnt_q == TO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^{32'(TIMEOUT)};
    assign err_c = 1'b0;
`endif

    // Next-state and slave-side register loads.
    always_comb begin
        state_d  = state_q;
        s_addr_d = s_addr_q;
        s_dout_d = s_dout_q;
        s_rd_d   = s_rd_q;
        s_wr_d   = s_wr_q;
        busy_d   = busy_q;
        grant_d  = grant_q;
        last_d   = last_q;
        done_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    state_d = ST_WAIT;
                    grant_d = pick_c;
                    last_d  = pick_c;
                    busy_d  = 1'b1;
                    // rd together with wr is treated as a write
                    if (pick_c) begin
                        s_addr_d = m1_addr;
                        s_dout_d = m1_dout;
                        s_wr_d   = m1_wr;
                        s_rd_d   = m1_rd & ~m1_wr;
                    end else begin
                        s_addr_d = m0_addr;
                        s_dout_d = m0_dout;
                        s_wr_d   = m0_wr;
                        s_rd_d   = m0_rd & ~m0_wr;
                    end
                end
            end
            ST_WAIT: begin
                if (s_ready || err_c) begin
                    done_c  = 1'b1;
                    state_d = ST_DONE;
                    s_rd_d  = 1'b0;
                    s_wr_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                // requests still high from the previous owner are ignored here
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s_addr_q <= '0;
            s_dout_q <= 8'h00;
            s_rd_q   <= 1'b0;
            s_wr_q   <= 1'b0;
            busy_q   <= 1'b0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            s_addr_q <= s_addr_d;
            s_dout_q <= s_dout_d;
            s_rd_q   <= s_rd_d;
            s_wr_q   <= s_wr_d;
            busy_q   <= busy_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    // Completion is suppressed while reset abandons the transaction.
    assign ack_c   = done_c & ~rst;
    assign rdata_c = s_ready ? s_din : ERR_RDATA;

    assign m0_ready = ack_c & ~grant_q;
    assign m1_ready = ack_c & grant_q;
    assign m0_din   = m0_ready ? rdata_c : 8'h00;
    assign m1_din   = m1_ready ? rdata_c : 8'h00;
    assign m_err    = err_c & ~rst;

    assign s_addr = s_addr_q;
    assign s_dout = s_dout_q;
    assign s_rd   = s_rd_q;
    assign s_wr   = s_wr_q;
    assign grant  = grant_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_isp8_ext_arb.sv
// Directed bench for isp8_ext_arb. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_isp8_ext_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] m0_addr, m0_dout, m0_din;
    logic       m0_rd, m0_wr, m0_ready;
    logic [7:0] m1_addr, m1_dout, m1_din;
    logic       m1_rd, m1_wr, m1_ready;
    logic [7:0] s_addr, s_dout, s_din;
    logic       s_rd, s_wr, s_ready;
    logic       grant, busy, m_err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    isp8_ext_arb #(.AW(8), .TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_addr  (m0_addr),
        .m0_dout  (m0_dout),
        .m0_rd    (m0_rd),
        .m0_wr    (m0_wr),
        .m0_din   (m0_din),
        .m0_ready (m0_ready),
        .m1_addr  (m1_addr),
        .m1_dout  (m1_dout),
        .m1_rd    (m1_rd),
        .m1_wr    (m1_wr),
        .m1_din   (m1_din),
        .m1_ready (m1_ready),
        .s_addr   (s_addr),
        .s_dout   (s_dout),
        .s_rd     (s_rd),
        .s_wr     (s_wr),
        .s_din    (s_din),
        .s_ready  (s_ready),
        .grant    (grant),
        .busy     (busy),
        .m_err    (m_err)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_addr = 8'h00; m0_dout = 8'h00; m0_rd = 1'b0; m0_wr = 1'b0;
        m1_addr = 8'h00; m1_dout = 8'h00; m1_rd = 1'b0; m1_wr = 1'b0;
        s_din = 8'h00; s_ready = 1'b0;

        // reset state
        nxt(); nxt(); smp();
        chk_b("rst_s_rd", s_rd, 1'b0);
        chk_b("rst_s_wr", s_wr, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_grant", grant, 1'b0);
        chk_b("rst_m_err", m_err, 1'b0);
        chk_v("rst_s_addr", s_addr, 8'h00);
        chk_v("rst_s_dout", s_dout, 8'h00);

        // single read, three wait cycles then ready
        nxt(); rst = 1'b0; m0_rd = 1'b1; m0_addr = 8'h12;
        smp();
        chk_b("rd_strobe_lag", s_rd, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (i == 3) begin s_ready = 1'b1; s_din = 8'hA5; end
            smp();
            chk_b("rd_s_rd", s_rd, 1'b1);
            chk_v("rd_s_addr", s_addr, 8'h12);
            chk_b("rd_m0_ready", m0_ready, (i == 3));
            chk_b("rd_m1_ready", m1_ready, 1'b0);
        end
        chk_v("rd_m0_din", m0_din, 8'hA5);
        chk_v("rd_m1_din", m1_din, 8'h00);
        chk_b("rd_busy", busy, 1'b1);
        chk_b("rd_grant", grant, 1'b0);
        nxt(); s_ready = 1'b0; m0_rd = 1'b0;
        smp();
        chk_b("rd_done_s_rd", s_rd, 1'b0);
        chk_b("rd_done_busy", busy, 1'b0);
        chk_b("rd_done_ready", m0_ready, 1'b0);
        nxt();

        // simultaneous requests right after reset
        rst = 1'b1;
        nxt(); rst = 1'b0;
        m0_wr = 1'b1; m0_addr = 8'h20; m0_dout = 8'h5A;
        m1_rd = 1'b1; m1_addr = 8'h30;
        nxt(); s_ready = 1'b1; s_din = 8'h11;
        smp();
        chk_b("sim_grant0", grant, 1'b0);
        chk_v("sim_addr0", s_addr, 8'h20);
        chk_v("sim_dout0", s_dout, 8'h5A);
        chk_b("sim_s_wr", s_wr, 1'b1);
        chk_b("sim_s_rd", s_rd, 1'b0);
        chk_b("sim_m0_ready", m0_ready, 1'b1);
        chk_b("sim_m1_ready", m1_ready, 1'b0);
        chk_v("sim_m1_din", m1_din, 8'h00);
        nxt(); s_ready = 1'b0; m0_wr = 1'b0;
        smp();
        chk_b("sim_done_busy", busy, 1'b0);
        chk_b("sim_done_s_wr", s_wr, 1'b0);
        nxt(); smp();
        chk_b("sim_idle_busy", busy, 1'b0);
        nxt(); s_ready = 1'b1; s_din = 8'h3C;
        smp();
        chk_b("sim_grant1", grant, 1'b1);
        chk_v("sim_addr1", s_addr, 8'h30);
        chk_b("sim_s_rd1", s_rd, 1'b1);
        chk_b("sim_m1_ready1", m1_ready, 1'b1);
        chk_v("sim_m1_din1", m1_din, 8'h3C);
        chk_b("sim_m0_ready1", m0_ready, 1'b0);
        chk_v("sim_m0_din1", m0_din, 8'h00);
        nxt(); s_ready = 1'b0; m1_rd = 1'b0;
        nxt();

        // continuous contention, zero-wait slave; last winner is m1
        m0_rd = 1'b1; m0_addr = 8'h40;
        m1_rd = 1'b1; m1_addr = 8'h50;
        s_ready = 1'b1; s_din = 8'h99;
        for (int t = 0; t < 6; t++) begin
            nxt(); smp();
            chk_b("cc_grant", grant, t[0]);
            chk_v("cc_addr", s_addr, t[0] ? 8'h50 : 8'h40);
            chk_b("cc_busy", busy, 1'b1);
            chk_b("cc_ready", t[0] ? m1_ready : m0_ready, 1'b1);
            nxt(); smp();
            chk_b("cc_gap_busy", busy, 1'b0);
            nxt();
        end
        m0_rd = 1'b0; m1_rd = 1'b0; s_ready = 1'b0;

        // m1 asserts rd and wr together
        m1_rd = 1'b1; m1_wr = 1'b1; m1_addr = 8'h60; m1_dout = 8'h77;
        nxt(); s_ready = 1'b1;
        smp();
        chk_b("rw_s_wr", s_wr, 1'b1);
        chk_b("rw_s_rd", s_rd, 1'b0);
        chk_v("rw_s_dout", s_dout, 8'h77);
        chk_v("rw_s_addr", s_addr, 8'h60);
        chk_b("rw_grant", grant, 1'b1);
        chk_b("rw_m1_ready", m1_ready, 1'b1);
        nxt(); s_ready = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
        nxt();

        // reset while in WAIT, then a tie must go to m0
        m0_rd = 1'b1; m0_addr = 8'h70;
        nxt(); rst = 1'b1;
        smp();
        chk_b("rw_pre_s_rd", s_rd, 1'b1);
        chk_b("rw_pre_ready", m0_ready, 1'b0);
        nxt(); rst = 1'b0;
        m0_addr = 8'h71; m1_rd = 1'b1; m1_addr = 8'h81;
        smp();
        chk_b("rstw_s_rd", s_rd, 1'b0);
        chk_b("rstw_busy", busy, 1'b0);
        chk_b("rstw_grant", grant, 1'b0);
        chk_b("rstw_m0_ready", m0_ready, 1'b0);
        nxt(); s_ready = 1'b1; s_din = 8'h5E;
        smp();
        chk_b("rstw_tie_grant", grant, 1'b0);
        chk_v("rstw_tie_addr", s_addr, 8'h71);
        chk_b("rstw_tie_ready", m0_ready, 1'b1);
        chk_v("rstw_tie_din", m0_din, 8'h5E);
        nxt(); s_ready = 1'b0; m0_rd = 1'b0;
        nxt();
        nxt(); s_ready = 1'b1;
        smp();
        chk_b("rstw_next_grant", grant, 1'b1);
        chk_v("rstw_next_addr", s_addr, 8'h81);
        chk_b("rstw_next_ready", m1_ready, 1'b1);
        nxt(); s_ready = 1'b0; m1_rd = 1'b0;
        nxt();

`ifdef ISP8_ARB_TIMEOUT_EN
        // timeout with no s_ready
        m0_rd = 1'b1; m0_addr = 8'h90; s_din = 8'h42;
        for (int i = 0; i < 4; i++) begin
            nxt(); smp();
            chk_b("to_s_rd", s_rd, 1'b1);
            chk_b("to_m0_ready", m0_ready, (i == 3));
            chk_b("to_m_err", m_err, (i == 3));
        end
        chk_v("to_m0_din", m0_din, 8'hFF);
        nxt(); m0_rd = 1'b0;
        smp();
        chk_b("to_done_m_err", m_err, 1'b0);
        chk_b("to_done_busy", busy, 1'b0);
        nxt(); m0_rd = 1'b1;
        // s_ready in the limit cycle wins
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (i == 3) begin s_ready = 1'b1; s_din = 8'hC3; end
            smp();
            chk_b("tor_m0_ready", m0_ready, (i == 3));
            chk_b("tor_m_err", m_err, 1'b0);
        end
        chk_v("tor_m0_din", m0_din, 8'hC3);
        nxt(); s_ready = 1'b0; m0_rd = 1'b0;
        nxt();
`else
        // without the timeout, WAIT holds indefinitely
        m0_rd = 1'b1; m0_addr = 8'h90;
        for (int i = 0; i < 8; i++) begin
            nxt(); smp();
            chk_b("hold_m0_ready", m0_ready, 1'b0);
            chk_b("hold_m_err", m_err, 1'b0);
        end
        chk_b("hold_busy", busy, 1'b1);
        nxt(); s_ready = 1'b1; s_din = 8'h24;
        smp();
        chk_b("hold_ready", m0_ready, 1'b1);
        chk_v("hold_din", m0_din, 8'h24);
        nxt(); s_ready = 1'b0; m0_rd = 1'b0;
        nxt();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
